// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Program counter and fetch controller for the instruction memory. Issues
// the memory address, accounts for the memory's one-cycle read latency so
// that data for cur_pc is always on imem_instr while running, and offers
// each instruction to decode over a valid/ready handshake. Handles branch
// redirects, backpressure, halting and a saturating retired-instruction count.
//
// Ports:
//   clk, reset   clock; asynchronous active-high reset
//   start        leave IDLE/HALT and begin fetching at PC 0
//   imem_addr    address to memory (registered by the memory on clk)
//   imem_instr   memory word for the address registered on the last edge
//   imem_done    memory end-of-program flag, aligned with imem_instr
//   instr        instruction to decode (passthrough of imem_instr)
//   instr_pc     PC of instr
//   instr_valid  instr is valid this cycle
//   instr_ready  decode accepts instr this cycle
//   br_taken     redirect request, honoured only on an accepted transfer
//   br_target    redirect address
//   halted       sequencer is in HALT
//   instr_count  number of accepted instructions, saturating
module fetch_sequencer #(
  parameter int              AW         = 8,
  parameter int              IW         = 9,
  parameter logic [IW-1:0]   HALT_INSTR = '0,
  parameter int              CW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_instr,
  input  logic          imem_done,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          halted,
  output logic [CW-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] cur_pc;
  logic [CW-1:0] count_q;

  logic in_run;
  logic transfer;
  logic is_halt_instr;

  // The done flag arrives with the data, so it must suppress valid in the
  // same cycle rather than one cycle late.
  assign in_run        = (state == RUN);
  assign instr_valid   = in_run & ~imem_done;
  assign transfer      = instr_valid & instr_ready;
  assign is_halt_instr = (imem_instr == HALT_INSTR);

  assign instr       = imem_instr;
  assign instr_pc    = cur_pc;
  assign halted      = (state == HALT);
  assign instr_count = count_q;

  // Address for the word needed next cycle. Re-reading cur_pc on stalls,
  // halts and done keeps the memory output aligned with cur_pc, and issuing
  // the branch target directly gives a zero-bubble redirect.
  always_comb begin
    imem_addr = '0;
    if (in_run) begin
      if (!transfer || is_halt_instr) begin
        imem_addr = cur_pc;
      end else if (br_taken) begin
        imem_addr = br_target;
      end else begin
        imem_addr = cur_pc + 1'b1;
      end
    end
  end

  // Sequencer state, PC and retired count. While running, the PC simply
  // follows the address just issued, so it always matches the returned data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cur_pc  <= '0;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cur_pc <= '0;
          end
        end
        RUN: begin
          if (imem_done) begin
            state <= HALT;
          end else if (instr_ready) begin
            if (count_q != '1) begin
              count_q <= count_q + 1'b1;
            end
            if (is_halt_instr) begin
              state <= HALT;
            end else begin
              cur_pc <= imem_addr;
            end
          end
        end
        HALT: begin
          if (start) begin
            state  <= RUN;
            cur_pc <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer: a directed per-cycle vector
// table, hand-written corner sequences (done flag, wrap, async reset), and
// a randomized run checked against a behavioural model. The counter width
// is reduced so that saturation is reached during the random run.
module tb_fetch_sequencer;

  localparam int AW   = 8;
  localparam int IW   = 9;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_instr;
  logic          imem_done;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          halted;
  logic [CW-1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0] mem      [256];
  logic          done_mem [256];

  fetch_sequencer #(
    .AW(AW), .IW(IW), .HALT_INSTR(9'h000), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .imem_done(imem_done),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .br_taken(br_taken), .br_target(br_target),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory with one cycle of latency
  always @(posedge clk) begin
    imem_instr <= mem[imem_addr];
    imem_done  <= done_mem[imem_addr];
  end

  typedef struct {
    logic          s;
    logic          r;
    logic          b;
    logic [AW-1:0] t;
    logic          valid;
    logic [AW-1:0] pc;
    logic          hlt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl [14];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic b,
                               input logic [AW-1:0] t);
    start       = s;
    instr_ready = r;
    br_taken    = b;
    br_target   = t;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_addr", imem_addr, 8'h00);
    checkOutput("rst_count", instr_count, 5'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) begin
      mem[i]      = IW'(256 + i);
      done_mem[i] = 1'b0;
    end
  endtask

  // Starts a run from IDLE; returns positioned in the first RUN cycle
  task automatic launch();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    next_cycle();
  endtask

  initial begin
    logic [AW-1:0] m_pc;
    int            m_mode;
    int            m_cnt;
    logic          s, r, b, ev, acc, dn;
    logic [AW-1:0] t, eaddr;
    logic [IW-1:0] word;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    fill_linear();
    mem[8'h44] = 9'h000;
    do_reset();

    // s r b t | valid pc halted count addr
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 5'd0, 8'h01};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 5'd1, 8'h02};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 8'h02, 1'b0, 5'd2, 8'h02};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 5'd2, 8'h02};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h90, 1'b1, 8'h02, 1'b0, 5'd2, 8'h02};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 5'd2, 8'h03};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h40, 1'b1, 8'h03, 1'b0, 5'd3, 8'h40};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 5'd4, 8'h41};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 8'h41, 1'b0, 5'd5, 8'h44};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 8'h44, 1'b0, 5'd6, 8'h44};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'h44, 1'b1, 5'd7, 8'h00};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 5'd7, 8'h01};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 5'd8, 8'h02};

    for (int k = 0; k < 14; k++) begin
      applyStimulus(tbl[k].s, tbl[k].r, tbl[k].b, tbl[k].t);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d_valid", k), instr_valid, tbl[k].valid);
      checkOutput($sformatf("tbl%0d_pc", k), instr_pc, tbl[k].pc);
      checkOutput($sformatf("tbl%0d_halted", k), halted, tbl[k].hlt);
      checkOutput($sformatf("tbl%0d_count", k), instr_count, tbl[k].cnt);
      checkOutput($sformatf("tbl%0d_addr", k), imem_addr, tbl[k].addr);
      if (tbl[k].valid) begin
        checkOutput($sformatf("tbl%0d_instr", k), instr, mem[tbl[k].pc]);
      end
      next_cycle();
    end

    // Done flag at PC 5: valid drops that cycle, halt next, PC 5 not counted
    do_reset();
    fill_linear();
    done_mem[5] = 1'b1;
    launch();
    for (int p = 0; p < 5; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      checkOutput("done_run_pc", instr_pc, p);
      checkOutput("done_run_valid", instr_valid, 1'b1);
      checkOutput("done_run_instr", instr, mem[p]);
      next_cycle();
    end
    @(negedge clk);
    checkOutput("done_valid", instr_valid, 1'b0);
    checkOutput("done_pc", instr_pc, 8'h05);
    checkOutput("done_addr", imem_addr, 8'h05);
    checkOutput("done_count", instr_count, 5'd5);
    next_cycle();
    @(negedge clk);
    checkOutput("done_halted", halted, 1'b1);
    checkOutput("done_halt_valid", instr_valid, 1'b0);
    checkOutput("done_halt_count", instr_count, 5'd5);
    checkOutput("done_halt_addr", imem_addr, 8'h00);
    next_cycle();

    // Branch to 0xFF, accept it, PC wraps to 0x00
    do_reset();
    fill_linear();
    launch();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
    @(negedge clk);
    checkOutput("wrap_br_addr", imem_addr, 8'hFF);
    next_cycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput("wrap_ff_pc", instr_pc, 8'hFF);
    checkOutput("wrap_ff_instr", instr, mem[255]);
    checkOutput("wrap_ff_addr", imem_addr, 8'h00);
    next_cycle();
    @(negedge clk);
    checkOutput("wrap_pc", instr_pc, 8'h00);
    checkOutput("wrap_valid", instr_valid, 1'b1);
    checkOutput("wrap_count", instr_count, 5'd2);
    next_cycle();

    // Asynchronous reset in the middle of a run at PC 7
    do_reset();
    fill_linear();
    launch();
    for (int p = 0; p < 7; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      next_cycle();
    end
    @(negedge clk);
    checkOutput("mid_pc", instr_pc, 8'h07);
    checkOutput("mid_count", instr_count, 5'd7);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_valid", instr_valid, 1'b0);
    checkOutput("mid_rst_addr", imem_addr, 8'h00);
    checkOutput("mid_rst_count", instr_count, 5'd0);
    checkOutput("mid_rst_pc", instr_pc, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h20);
      @(negedge clk);
      checkOutput("mid_idle_valid", instr_valid, 1'b0);
      checkOutput("mid_idle_halted", halted, 1'b0);
      next_cycle();
    end

    // Randomized run against a behavioural model
    for (int i = 0; i < 256; i++) begin
      int v;
      v = int'($urandom % 512);
      if (v == 0) v = 1;
      if ($urandom % 40 == 0) v = 0;
      mem[i]      = IW'(v);
      done_mem[i] = ($urandom % 60 == 0);
    end
    do_reset();
    m_mode = 0;
    m_pc   = '0;
    m_cnt  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        m_mode = 0;
        m_pc   = '0;
        m_cnt  = 0;
      end
      s = ($urandom % 4 == 0);
      r = ($urandom % 10 < 7);
      b = ($urandom % 7 == 0);
      t = AW'($urandom);
      applyStimulus(s, r, b, t);

      dn   = done_mem[m_pc];
      word = mem[m_pc];
      ev   = (m_mode == 1) && !dn;
      acc  = ev && r;
      if (m_mode != 1)       eaddr = 8'h00;
      else if (!acc)         eaddr = m_pc;
      else if (word == 9'h0) eaddr = m_pc;
      else if (b)            eaddr = t;
      else                   eaddr = m_pc + 8'd1;

      @(negedge clk);
      checkOutput("rnd_valid", instr_valid, ev);
      checkOutput("rnd_pc", instr_pc, m_pc);
      checkOutput("rnd_halted", halted, m_mode == 2);
      checkOutput("rnd_count", instr_count, m_cnt);
      checkOutput("rnd_addr", imem_addr, eaddr);
      if (m_mode == 1) begin
        checkOutput("rnd_instr", instr, word);
      end
      next_cycle();

      if (m_mode != 1) begin
        if (s) begin
          m_mode = 1;
          m_pc   = '0;
        end
      end else if (dn) begin
        m_mode = 2;
      end else if (acc) begin
        m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        if (word == 9'h0) m_mode = 2;
        else              m_pc = eaddr;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
